keypad_scan_encoder: RTL and testbench
======================================

KEYPAD_SCAN_ENCODER -- requirements
Module: keypad_scan_encoder

Interface
REQ-001 SHALL have parameter DWELL_CYC, default 1000, meaning clock cycles each column is driven (minimum 4).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port o_col_n  output  3  column drive, one-hot active-low.
REQ-005 SHALL have port o_sync_n  output  1  active-low one-cycle sample strobe to the row button filters.
REQ-006 SHALL have port i_btn_push  input  4  per-row one-cycle press pulses from the row filters.
REQ-007 SHALL have port i_btn_save  input  4  per-row held-level indications from the row filters.
REQ-008 SHALL have port o_key_code  output  4  encoded key, row*3+col, range 0..11.
REQ-009 SHALL have port o_key_valid  output  1  o_key_code holds an unconsumed key.
REQ-010 SHALL have port i_key_ready  input  1  consumer accepts the key when high together with o_key_valid.
REQ-011 SHALL have port o_overflow  output  1  sticky flag: a key was dropped.

Function
REQ-012 SHALL keep a dwell counter 0..DWELL_CYC-1 and a column index 0..2; o_col_n = ~(1<<col).
REQ-013 SHALL drive o_sync_n low for exactly the cycle where dwell counter = DWELL_CYC-1, high otherwise.
REQ-014 SHALL, in the cycle after the sync cycle, restart the dwell counter at 0 and advance col 0->1->2->0, unless i_btn_save != 0 in the sync cycle, in which case col holds (scan freeze while a key is held).
REQ-015 SHALL attribute any i_btn_push pulse to the column driven in that same cycle, including the sync cycle.
REQ-016 SHALL, when several i_btn_push bits are high in one cycle, encode only the lowest-index row; the others are discarded without setting o_overflow.
REQ-017 SHALL present a key accepted on cycle N at o_key_code with o_key_valid=1 on cycle N+1 (latency 1 from empty).
REQ-018 SHALL hold o_key_code and o_key_valid stable while o_key_valid=1 and i_key_ready=0.
REQ-019 SHALL consume the presented key on any cycle with o_key_valid=1 and i_key_ready=1.
REQ-020 SHALL, when a push arrives and storage is full with no consumption that cycle, drop the new key and set o_overflow=1 until reset.
REQ-021 SHALL, when a push and a consumption coincide with storage full, accept the new key (no drop, no overflow).
REQ-022 SHALL ignore i_key_ready while o_key_valid=0.

Reset
REQ-023 SHALL, in a cycle with rst=1, set col=0, dwell counter=0, o_col_n=3'b110, o_sync_n=1, o_key_code=0, o_key_valid=0, o_overflow=0, storage emptied.
REQ-024 SHALL, when rst asserts mid-dwell or with keys pending, discard everything; a push in the rst cycle is lost.
REQ-025 SHALL start counting at dwell 0 on the first cycle after rst deasserts.

Configuration
REQ-026 SHALL with macro KEYPAD_KEY_FIFO_EN defined buffer keys in a 4-entry FIFO (full = 4 stored, order preserved).
REQ-027 SHALL without KEYPAD_KEY_FIFO_EN use a single holding register (full = o_key_valid=1); port list identical in both builds.

Structure
REQ-028 SHALL take NUM_ROW=4, NUM_COL=3, KEY_W=4, KEY_FIFO_DEPTH=4 and the key-code type from shared package keypad_pkg.
REQ-029 SHALL place the FIFO in sub-module keypad_key_fifo, instantiated only under KEYPAD_KEY_FIFO_EN.

Verification (DWELL_CYC=8)
REQ-030 SHALL cover: rst then idle 24 cycles -> o_col_n 110/101/011 for 8 cycles each, o_sync_n low on cycles 7, 15, 23.
REQ-031 SHALL cover: i_btn_push=4'b0100 during col 1, ready=1 -> next cycle o_key_code=7, o_key_valid=1 for one cycle.
REQ-032 SHALL cover: i_btn_save=4'b0001 held across sync while col=2 -> col stays 2 until save clears, then advances to 0.
REQ-033 SHALL cover: i_btn_push=4'b1010 in col 0 -> single key code 3.
REQ-034 SHALL cover: ready=0, five pushes (FIFO build) or two pushes (no-FIFO build) -> o_overflow=1, first stored codes delivered in order once ready=1.
REQ-035 SHALL cover: rst pulsed with 2 keys pending at col 2 -> o_key_valid=0, o_overflow=0, o_col_n=110 next cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad scan/encode types and sizes.
// Used by keypad_scan_encoder and keypad_key_fifo.
package keypad_pkg;

  localparam int NUM_ROW        = 4;
  localparam int NUM_COL        = 3;
  localparam int KEY_W          = 4;
  localparam int KEY_FIFO_DEPTH = 4;

  typedef logic [KEY_W-1:0] key_code_t;

  function automatic key_code_t key_encode(
    input logic [1:0] row,
    input logic [1:0] col
  );
    return key_code_t'(int'(row) * NUM_COL + int'(col));
  endfunction

endpackage

// File: rtl/keypad_scan_encoder_if.sv
// Keypad encoder signal bundle: column drive,
// row filter strobes and key-out handshake.
interface keypad_scan_encoder_if;
  import keypad_pkg::*;

  logic [NUM_COL-1:0] col_n;
  logic               sync_n;
  logic [NUM_ROW-1:0] btn_push;
  logic [NUM_ROW-1:0] btn_save;
  key_code_t          key_code;
  logic               key_valid;
  logic               key_ready;
  logic               overflow;

  modport master (
    output col_n, sync_n,
    output key_code, key_valid, overflow,
    input  btn_push, btn_save, key_ready
  );

  modport slave (
    input  col_n, sync_n,
    input  key_code, key_valid, overflow,
    output btn_push, btn_save, key_ready
  );

endinterface

// File: rtl/keypad_key_fifo.sv
// 4-entry key FIFO; built only with KEYPAD_KEY_FIFO_EN.
// Push while full is accepted only if a pop coincides.
`ifdef KEYPAD_KEY_FIFO_EN
module keypad_key_fifo
  import keypad_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  key_code_t i_data,
  input  logic      i_pop,
  output key_code_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int PTR_W = $clog2(KEY_FIFO_DEPTH);

  key_code_t        mem [KEY_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             wr;
  logic             rd;

  assign o_full  = (count == (PTR_W+1)'(KEY_FIFO_DEPTH));
  assign o_empty = (count == '0);
  assign rd      = i_pop & ~o_empty;
  assign wr      = i_push & (~o_full | rd);
  assign o_data  = o_empty ? '0 : mem[rd_ptr];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= i_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr, rd})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`endif

// File: rtl/keypad_scan_encoder.sv
// Keypad column scanner and key encoder.
// KEYPAD_KEY_FIFO_EN: 4-deep key FIFO instead of one register.
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int DWELL_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [NUM_COL-1:0] o_col_n,
  output logic               o_sync_n,
  input  logic [NUM_ROW-1:0] i_btn_push,
  input  logic [NUM_ROW-1:0] i_btn_save,
  output key_code_t          o_key_code,
  output logic               o_key_valid,
  input  logic               i_key_ready,
  output logic               o_overflow
);

  localparam int CNT_W = $clog2(DWELL_CYC);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       col;
  logic             sync;
  logic [1:0]       push_row;
  logic             push_any;
  key_code_t        push_code;
  logic             consume;
  logic             drop;

  assign sync     = (cnt == CNT_W'(DWELL_CYC - 1));
  assign o_sync_n = ~sync;
  assign o_col_n  = ~(3'b001 << col);

  // dwell counter and column; freeze column while a key is held
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      col <= '0;
    end else if (sync) begin
      cnt <= '0;
      if (i_btn_save == '0)
        col <= (col == 2'd2) ? 2'd0 : col + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // lowest pushed row wins; others discarded
  always_comb begin
    push_row = 2'd0;
    priority case (1'b1)
      i_btn_push[0]: push_row = 2'd0;
      i_btn_push[1]: push_row = 2'd1;
      i_btn_push[2]: push_row = 2'd2;
      i_btn_push[3]: push_row = 2'd3;
      default:       push_row = 2'd0;
    endcase
  end

  assign push_any  = |i_btn_push;
  assign push_code = key_encode(push_row, col);
  assign consume   = o_key_valid & i_key_ready;

`ifdef KEYPAD_KEY_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  keypad_key_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (push_any),
    .i_data  (push_code),
    .i_pop   (consume),
    .o_data  (o_key_code),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_key_valid = ~fifo_empty;
  assign drop        = push_any & fifo_full & ~consume;
`else
  key_code_t hold_code;
  logic      hold_valid;
  logic      load;

  assign load        = push_any & (~hold_valid | consume);
  assign drop        = push_any & hold_valid & ~consume;
  assign o_key_code  = hold_code;
  assign o_key_valid = hold_valid;

  // single holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_code  <= '0;
      hold_valid <= 1'b0;
    end else if (load) begin
      hold_code  <= push_code;
      hold_valid <= 1'b1;
    end else if (consume) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // sticky drop flag
  always_ff @(posedge clk) begin
    if (rst)       o_overflow <= 1'b0;
    else if (drop) o_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder, DWELL_CYC=8,
// with a key scoreboard checked on consumption.
module tb_keypad_scan_encoder;
  import keypad_pkg::*;

  localparam int DW = 8;
`ifdef KEYPAD_KEY_FIFO_EN
  localparam int CAP = KEY_FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_encoder_if bus ();

  keypad_scan_encoder #(.DWELL_CYC(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .o_col_n     (bus.col_n),
    .o_sync_n    (bus.sync_n),
    .i_btn_push  (bus.btn_push),
    .i_btn_save  (bus.btn_save),
    .o_key_code  (bus.key_code),
    .o_key_valid (bus.key_valid),
    .i_key_ready (bus.key_ready),
    .o_overflow  (bus.overflow)
  );

  int        n_vec = 0;
  int        n_err = 0;
  key_code_t exp_q[$];

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.btn_push  = '0;
    bus.btn_save  = '0;
    bus.key_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [2:0] col_pat(input int c);
    logic [2:0] p;
    p = 3'b111;
    p[c] = 1'b0;
    return p;
  endfunction

  // scoreboard: compare each consumed key
  always @(negedge clk) begin
    if (!rst && bus.key_valid === 1'b1 &&
        bus.key_ready === 1'b1) begin
      if (exp_q.size() == 0)
        chk("key_unexpected", 8'(bus.key_code), 8'hff);
      else
        chk("key_code", 8'(bus.key_code),
            8'(exp_q.pop_front()));
    end
  end

  initial begin
    bus.btn_push  = '0;
    bus.btn_save  = '0;
    bus.key_ready = 1'b0;

    // reset state and scan sequence
    do_reset();
    chk("rst_valid", 8'(bus.key_valid), 8'd0);
    chk("rst_ovf", 8'(bus.overflow), 8'd0);
    chk("rst_code", 8'(bus.key_code), 8'd0);
    for (int i = 0; i < 3 * DW; i++) begin
      chk("scan_col", 8'(bus.col_n), 8'(col_pat(i / DW)));
      chk("scan_sync", 8'(bus.sync_n),
          8'((i % DW == DW - 1) ? 0 : 1));
      tick();
    end
    chk("scan_wrap", 8'(bus.col_n), 8'(col_pat(0)));

    // row 2 in col 1 -> code 7, one cycle
    do_reset();
    bus.key_ready = 1'b1;
    ticks(DW);
    bus.btn_push = 4'b0100;
    exp_q.push_back(key_code_t'(7));
    tick();
    bus.btn_push = '0;
    chk("k7_valid", 8'(bus.key_valid), 8'd1);
    chk("k7_code", 8'(bus.key_code), 8'd7);
    tick();
    chk("k7_gone", 8'(bus.key_valid), 8'd0);

    // multi-row push in col 0 -> single code 3
    do_reset();
    bus.key_ready = 1'b1;
    bus.btn_push = 4'b1010;
    exp_q.push_back(key_code_t'(3));
    tick();
    bus.btn_push = '0;
    chk("k3_valid", 8'(bus.key_valid), 8'd1);
    chk("k3_code", 8'(bus.key_code), 8'd3);
    tick();
    chk("k3_single", 8'(bus.key_valid), 8'd0);
    chk("k3_ovf", 8'(bus.overflow), 8'd0);

    // push on the sync cycle belongs to the old column
    do_reset();
    bus.key_ready = 1'b1;
    ticks(DW - 1);
    chk("sp_sync", 8'(bus.sync_n), 8'd0);
    bus.btn_push = 4'b0100;
    exp_q.push_back(key_code_t'(6));
    tick();
    bus.btn_push = '0;
    chk("sp_col", 8'(bus.col_n), 8'(col_pat(1)));
    chk("sp_code", 8'(bus.key_code), 8'd6);
    tick();

    // held key freezes column 2
    do_reset();
    ticks(2 * DW);
    chk("hold_c2", 8'(bus.col_n), 8'(col_pat(2)));
    bus.btn_save = 4'b0001;
    ticks(DW);
    chk("hold_a", 8'(bus.col_n), 8'(col_pat(2)));
    ticks(DW);
    chk("hold_b", 8'(bus.col_n), 8'(col_pat(2)));
    bus.btn_save = '0;
    ticks(DW - 1);
    chk("hold_sync", 8'(bus.sync_n), 8'd0);
    chk("hold_c", 8'(bus.col_n), 8'(col_pat(2)));
    tick();
    chk("hold_adv", 8'(bus.col_n), 8'(col_pat(0)));

    // push and consume coincide while full
    do_reset();
    bus.btn_push = 4'b1000;
    exp_q.push_back(key_code_t'(9));
    tick();
    chk("co_valid", 8'(bus.key_valid), 8'd1);
    bus.key_ready = 1'b1;
    bus.btn_push = 4'b0001;
    exp_q.push_back(key_code_t'(0));
    tick();
    bus.btn_push = '0;
    chk("co_ovf", 8'(bus.overflow), 8'd0);
    chk("co_valid2", 8'(bus.key_valid), 8'd1);
    chk("co_code", 8'(bus.key_code), 8'd0);
    tick();
    chk("co_empty", 8'(bus.key_valid), 8'd0);

    // overflow: fill storage, one more push drops
    do_reset();
    for (int i = 0; i < CAP + 1; i++) begin
      bus.btn_push = 4'(1 << (i % 4));
      if (i < CAP)
        exp_q.push_back(key_code_t'((i % 4) * 3));
      tick();
    end
    bus.btn_push = '0;
    chk("of_flag", 8'(bus.overflow), 8'd1);
    chk("of_valid", 8'(bus.key_valid), 8'd1);
    chk("of_head", 8'(bus.key_code), 8'd0);
    tick();
    chk("of_stable", 8'(bus.key_code), 8'd0);
    bus.key_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      tick();
    chk("of_drained", 8'(exp_q.size()), 8'd0);
    chk("of_empty", 8'(bus.key_valid), 8'd0);
    chk("of_sticky", 8'(bus.overflow), 8'd1);

    // reset with keys pending in col 2
    do_reset();
    ticks(2 * DW);
    bus.btn_push = 4'b0001;
    tick();
    bus.btn_push = 4'b0010;
    tick();
    chk("rp_pend", 8'(bus.key_valid), 8'd1);
    rst = 1'b1;
    bus.btn_push = 4'b1000;
    tick();
    rst = 1'b0;
    bus.btn_push = '0;
    exp_q.delete();
    chk("rp_valid", 8'(bus.key_valid), 8'd0);
    chk("rp_ovf", 8'(bus.overflow), 8'd0);
    chk("rp_col", 8'(bus.col_n), 8'(col_pat(0)));
    chk("rp_sync", 8'(bus.sync_n), 8'd1);
    bus.key_ready = 1'b1;
    ticks(3);
    chk("rp_lost", 8'(bus.key_valid), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
